// File: rtl/rr_arbiter_ctl.sv
// N-way arbiter (round-robin or fixed-priority) with a grant-hold limit and opcode control for force/release/on/off.
// Grant and error flag are registered one edge after inputs are sampled. The grant is a hint and cannot be backpressured.
module rr_arbiter_ctl #(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [2:0]     opcode,
  input  logic [IDW-1:0] op_idx,
  output logic [N-1:0]   gnt,
  output logic           op_error
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  localparam logic [2:0] OP_FORCE   = 3'd1;
  localparam logic [2:0] OP_RELEASE = 3'd2;
  localparam logic [2:0] OP_A_OFF   = 3'd3;
  localparam logic [2:0] OP_A_ON    = 3'd4;
  localparam logic [2:0] OP_RR_MODE = 3'd5;
  localparam logic [2:0] OP_FP_MODE = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  typedef enum logic [1:0] {ST_ARB, ST_FORCED, ST_OFF} state_t;

  state_t         state, state_nxt;
  logic           mode_fp, mode_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]   gnt_nxt;
  logic           err_nxt;

  logic           force_ok;
  logic           fresh;
  logic [N-1:0]   owner, others;
  logic           keep;
  int             rr_pos;
  logic           rr_found, fp_found, win_found;
  logic [IDW-1:0] rr_idx, fp_idx, win_idx;
  logic [N-1:0]   arb_gnt;
  logic [HW-1:0]  arb_hold;
  logic [IDW-1:0] arb_ptr;

  assign force_ok = (opcode == OP_FORCE) && (int'(op_idx) < N);
  assign err_nxt  = (opcode == OP_RSVD)
                  || ((opcode == OP_FORCE) && !force_ok)
                  || ((opcode == OP_RELEASE) && (state != ST_FORCED));

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_ARB;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (force_ok)                                                 state_nxt = ST_FORCED;
    else if (opcode == OP_A_OFF)                                  state_nxt = ST_OFF;
    else if ((opcode == OP_RELEASE) && (state == ST_FORCED))      state_nxt = ST_ARB;
    else if (opcode == OP_A_ON)                                   state_nxt = ST_ARB;
  end

  // Re-entering ARB from FORCED/OFF arbitrates fresh: the forced grant never counts as an owner.
  assign fresh  = (state != ST_ARB);
  assign owner  = fresh ? '0 : gnt;
  assign others = req & ~owner;
  assign keep   = (|(req & owner)) && ((hold_cnt < HOLD_LIM) || (others == '0));

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    fp_found = 1'b0;
    fp_idx   = '0;
    for (int i = 0; i < N; i++) begin
      rr_pos = int'(ptr) + i;
      if (rr_pos >= N) rr_pos = rr_pos - N;
      if (!rr_found && others[IDW'(rr_pos)]) begin
        rr_found = 1'b1;
        rr_idx   = IDW'(rr_pos);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (others[i]) begin
        fp_found = 1'b1;
        fp_idx   = IDW'(i);
      end
    end
  end

  assign win_found = mode_fp ? fp_found : rr_found;
  assign win_idx   = mode_fp ? fp_idx : rr_idx;

  always_comb begin
    arb_gnt  = '0;
    arb_hold = '0;
    arb_ptr  = ptr;
    if (keep) begin
      arb_gnt  = owner;
      arb_hold = (others == '0) ? '0 : hold_cnt + HW'(1);
    end else if (win_found) begin
      arb_gnt = N'(1) << win_idx;
      arb_ptr = (int'(win_idx) == N - 1) ? '0 : win_idx + IDW'(1);
    end
  end

  always_comb begin
    gnt_nxt  = gnt;
    hold_nxt = hold_cnt;
    ptr_nxt  = ptr;
    mode_nxt = mode_fp;
    if (opcode == OP_RR_MODE) mode_nxt = 1'b0;
    if (opcode == OP_FP_MODE) mode_nxt = 1'b1;
    case (state_nxt)
      ST_FORCED: if (force_ok) gnt_nxt = N'(1) << op_idx;
      ST_OFF:    gnt_nxt = '0;
      default: begin
        gnt_nxt  = arb_gnt;
        hold_nxt = arb_hold;
        ptr_nxt  = arb_ptr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt      <= '0;
      op_error <= 1'b0;
      mode_fp  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      gnt      <= gnt_nxt;
      op_error <= err_nxt;
      mode_fp  <= mode_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_ctl.sv
// Directed vectors against a 4-way and a 3-way arbiter; expectations are queued by the driver and checked by a monitor.
module tb_rr_arbiter_ctl;

  localparam logic [2:0] NOP = 3'd0, FRC = 3'd1, REL = 3'd2, OFF = 3'd3,
                         ON  = 3'd4, RRM = 3'd5, FPM = 3'd6, RSV = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [2:0] opcode = NOP;
  logic [1:0] op_idx = '0;
  logic [3:0] gnt;
  logic       op_error;

  logic [2:0] req3 = '0;
  logic [2:0] opcode3 = NOP;
  logic [1:0] op_idx3 = '0;
  logic [2:0] gnt3;
  logic       op_error3;

  typedef struct {
    bit         which;
    logic [3:0] gnt;
    logic       err;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rr_arbiter_ctl #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .opcode(opcode), .op_idx(op_idx),
    .gnt(gnt), .op_error(op_error)
  );

  rr_arbiter_ctl #(.N(3), .MAX_HOLD(4)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .opcode(opcode3), .op_idx(op_idx3),
    .gnt(gnt3), .op_error(op_error3)
  );

  task automatic vec(input logic r, input logic [3:0] rq, input logic [2:0] op,
                     input logic [1:0] idx, input logic [3:0] eg, input logic ee,
                     input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; opcode = op; op_idx = idx;
    e.which = 1'b0; e.gnt = eg; e.err = ee; e.name = nm;
    q.push_back(e);
  endtask

  task automatic vec3(input logic [2:0] rq, input logic [2:0] op, input logic [1:0] idx,
                      input logic [2:0] eg, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; req3 = rq; opcode3 = op; op_idx3 = idx;
    e.which = 1'b1; e.gnt = {1'b0, eg}; e.err = ee; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: one expectation per driven edge, checked just after that edge.
  initial begin
    exp_t       e;
    logic [3:0] g;
    logic       er;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        g  = e.which ? {1'b0, gnt3} : gnt;
        er = e.which ? op_error3 : op_error;
        n_vec++;
        if (g !== e.gnt || er !== e.err) begin
          n_bad++;
          $display("FAIL %s: got gnt=%b op_error=%b, expected gnt=%b op_error=%b",
                   e.name, g, er, e.gnt, e.err);
        end
      end
    end
  end

  initial begin
    logic [3:0] eg;
    int         waited;

    // Reset wins even over an illegal opcode
    vec(0, 4'b1111, RSV, 0, 4'b0000, 0, "reset");
    vec(0, 4'b1111, RSV, 0, 4'b0000, 0, "reset_hold");

    // All requesting: each owner held MAX_HOLD cycles, then rotate
    for (int k = 0; k < 17; k++) begin
      eg = 4'b0001;
      if (k < 16) eg = eg << (k / 4);
      vec(1, 4'b1111, NOP, 0, eg, 0, "rr_rotate");
    end

    // Sole requester never rotates away
    repeat (10) vec(1, 4'b0100, NOP, 0, 4'b0100, 0, "sole_req");
    vec(1, 4'b0000, NOP, 0, 4'b0000, 0, "no_req");

    // Fixed priority ignores ptr, still honours the hold limit
    vec(1, 4'b0000, FPM, 0, 4'b0000, 0, "fp_set");
    vec(1, 4'b1010, NOP, 0, 4'b0010, 0, "fp_low_a");
    vec(1, 4'b0000, NOP, 0, 4'b0000, 0, "fp_drop_a");
    vec(1, 4'b1010, NOP, 0, 4'b0010, 0, "fp_low_b");
    vec(1, 4'b0000, NOP, 0, 4'b0000, 0, "fp_drop_b");
    for (int k = 0; k < 6; k++)
      vec(1, 4'b1010, NOP, 0, (k < 4) ? 4'b0010 : 4'b1000, 0, "fp_hold_expire");
    vec(1, 4'b0010, NOP, 0, 4'b0010, 0, "fp_set_ptr2");
    vec(1, 4'b0000, NOP, 0, 4'b0000, 0, "fp_idle");
    vec(1, 4'b0000, RRM, 0, 4'b0000, 0, "rr_set");
    vec(1, 4'b1010, NOP, 0, 4'b1000, 0, "rr_from_ptr2");

    // Force, hold regardless of req, retarget, release
    vec(1, 4'b0000, FRC, 3, 4'b1000, 0, "force3");
    vec(1, 4'b0000, NOP, 0, 4'b1000, 0, "force_hold_a");
    vec(1, 4'b0000, NOP, 0, 4'b1000, 0, "force_hold_b");
    vec(1, 4'b0100, FRC, 1, 4'b0010, 0, "force_retarget");
    vec(1, 4'b0001, REL, 0, 4'b0001, 0, "release");
    vec(1, 4'b0001, NOP, 0, 4'b0001, 0, "after_release");

    // Errors: single pulse, back-to-back pulses, grant unaffected
    vec(1, 4'b0001, RSV, 0, 4'b0001, 1, "err_rsvd");
    vec(1, 4'b0001, NOP, 0, 4'b0001, 0, "err_clear");
    vec(1, 4'b0001, RSV, 0, 4'b0001, 1, "err_b2b_a");
    vec(1, 4'b0001, REL, 0, 4'b0001, 1, "err_release_arb");
    vec(1, 4'b0001, NOP, 0, 4'b0001, 0, "err_clear_b");

    // Off, resume from preserved ptr, A_ON in ARB is a no-op
    vec(1, 4'b1111, OFF, 0, 4'b0000, 0, "off");
    vec(1, 4'b1111, NOP, 0, 4'b0000, 0, "off_hold_a");
    vec(1, 4'b1111, NOP, 0, 4'b0000, 0, "off_hold_b");
    vec(1, 4'b1111, ON,  0, 4'b0010, 0, "on_resume");
    vec(1, 4'b1111, ON,  0, 4'b0010, 0, "on_in_arb");
    vec(1, 4'b1111, FPM, 0, 4'b0010, 0, "fp_while_owned");
    vec(1, 4'b1111, FRC, 2, 4'b0100, 0, "force2");

    // Reset mid-force clears grant, error, mode and ptr
    vec(0, 4'b1111, RSV, 2, 4'b0000, 0, "rst_mid_force");
    vec(1, 4'b0010, NOP, 0, 4'b0010, 0, "post_rst_grant");
    vec(1, 4'b1001, NOP, 0, 4'b1000, 0, "post_rst_rr_mode");

    // 3-way build: out-of-range FORCE is an error and leaves ARB running
    vec3(3'b001, NOP, 0, 3'b001, 0, "n3_arb");
    vec3(3'b001, FRC, 3, 3'b001, 1, "n3_force_bad");
    vec3(3'b010, NOP, 0, 3'b010, 0, "n3_still_arb");
    vec3(3'b001, FRC, 2, 3'b100, 0, "n3_force2");
    vec3(3'b001, REL, 0, 3'b001, 0, "n3_release");

    @(negedge clk);
    req3 = '0; opcode3 = NOP; opcode = NOP;
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
